// File: rtl/fp_unpack_if.sv
// Producer/consumer bundle for the FP operand unpacker: packed word in, decoded operand out.
interface fp_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        unp_op;
  logic        unp_s;
  logic [7:0]  unp_e;
  logic [23:0] unp_m;
  logic        unp_zero;
  logic        unp_inf;
  logic        unp_nan;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, unp_op, unp_s, unp_e, unp_m, unp_zero, unp_inf, unp_nan
  );
  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, unp_op, unp_s, unp_e, unp_m, unp_zero, unp_inf, unp_nan
  );
endinterface

// File: rtl/fp_unpack.sv
// FP16/FP32 operand decoder feeding a small FIFO in front of the MAC multiplier.
// Define FP_UNPACK_FTZ_EN to flush subnormal inputs to signed zero.
module fp_unpack #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input logic     clk,
  input logic     rst,
  fp_unpack_if.slave io
);
  typedef struct packed {
    logic        op;
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        zero;
    logic        inf;
    logic        nan;
  } unp_t;

  unp_t             dec;
  unp_t             head;
  unp_t             mem_q [DEPTH];
  unp_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       ex, emax;
  logic [23:0]      fr, hid;
  logic             push, pop;

  always_comb begin
    dec    = '0;
    dec.op = io.in_op;
    if (io.in_op) begin
      dec.s = io.in_data[31];
      ex    = io.in_data[30:23];
      emax  = 8'hFF;
      fr    = {1'b0, io.in_data[22:0]};
      hid   = 24'h80_0000;
    end else begin
      dec.s = io.in_data[15];
      ex    = {3'd0, io.in_data[14:10]};
      emax  = 8'h1F;
      fr    = {14'd0, io.in_data[9:0]};
      hid   = 24'h00_0400;
    end
    if (ex == 8'd0 && fr == 24'd0) begin
      dec.zero = 1'b1;
    end else if (ex == emax) begin
      dec.e   = emax;
      dec.m   = hid | fr;
      dec.inf = (fr == 24'd0);
      dec.nan = (fr != 24'd0);
    end else if (ex == 8'd0) begin
`ifdef FP_UNPACK_FTZ_EN
      dec.zero = 1'b1;
`else
      // subnormal: hidden bit clear, effective exponent 1
      dec.e = 8'd1;
      dec.m = fr;
`endif
    end else begin
      dec.e = ex;
      dec.m = hid | fr;
    end
  end

  assign io.in_ready  = (count_q != (PTR_W+1)'(DEPTH));
  assign io.out_valid = (count_q != '0);
  assign push         = io.in_valid & io.in_ready;
  assign pop          = io.out_valid & io.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head        = io.out_valid ? mem_q[rd_ptr_q] : '0;
  assign io.unp_op   = head.op;
  assign io.unp_s    = head.s;
  assign io.unp_e    = head.e;
  assign io.unp_m    = head.m;
  assign io.unp_zero = head.zero;
  assign io.unp_inf  = head.inf;
  assign io.unp_nan  = head.nan;
endmodule

// File: tb/tb_fp_unpack.sv
// Scoreboard bench for fp_unpack: directed words in, monitor compares every output handshake.
module tb_fp_unpack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fp_unpack_if bus ();

  fp_unpack #(.DEPTH(2), .PTR_W(1)) dut (.clk(clk), .rst(rst), .io(bus.slave));

  always #5 clk = ~clk;

  // {op, s, e[7:0], m[23:0], zero, inf, nan}
  logic [36:0] sb [$];
  int n_cmp = 0, n_bad = 0, n_sent = 0, n_disc = 0, n_out = 0;

  function automatic logic [36:0] mk(input logic op, input logic s, input logic [7:0] e,
                                     input logic [23:0] m, input logic z, input logic i, input logic n);
    return {op, s, e, m, z, i, n};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %0h expected none",
                 {bus.unp_op, bus.unp_s, bus.unp_e, bus.unp_m, bus.unp_zero, bus.unp_inf, bus.unp_nan});
      end else begin
        logic [36:0] e;
        logic [36:0] a;
        e = sb.pop_front();
        a = {bus.unp_op, bus.unp_s, bus.unp_e, bus.unp_m, bus.unp_zero, bus.unp_inf, bus.unp_nan};
        if (a !== e) begin
          n_bad++;
          $display("FAIL output_%0d: got %0h expected %0h", n_out, a, e);
        end
      end
    end
  end

  // holds in_valid high on return so consecutive calls are back-to-back
  task automatic send(input logic op, input logic [31:0] d, input logic [36:0] exp);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(exp);
      n_sent++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_unp", 64'({bus.unp_op, bus.unp_s, bus.unp_e, bus.unp_m, bus.unp_zero, bus.unp_inf, bus.unp_nan}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // single FP32 word: visible one cycle after acceptance
    send(1'b1, 32'h3F80_0000, mk(1, 0, 8'h7F, 24'h80_0000, 0, 0, 0));
    idle();
    check("latency_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;

    // back-to-back FP16
    send(1'b0, 32'h0000_3C00, mk(0, 0, 8'h0F, 24'h00_0400, 0, 0, 0));
    send(1'b0, 32'h0000_FC00, mk(0, 1, 8'h1F, 24'h00_0400, 0, 1, 0));
    send(1'b1, 32'h7FC0_0000, mk(1, 0, 8'hFF, 24'hC0_0000, 0, 0, 1));
    send(1'b1, 32'h8000_0000, mk(1, 1, 8'h00, 24'h00_0000, 1, 0, 0));
`ifdef FP_UNPACK_FTZ_EN
    send(1'b1, 32'h0000_0001, mk(1, 0, 8'h00, 24'h00_0000, 1, 0, 0));
    send(1'b0, 32'h0000_8001, mk(0, 1, 8'h00, 24'h00_0000, 1, 0, 0));
`else
    send(1'b1, 32'h0000_0001, mk(1, 0, 8'h01, 24'h00_0001, 0, 0, 0));
    send(1'b0, 32'h0000_8001, mk(0, 1, 8'h01, 24'h00_0001, 0, 0, 0));
`endif
    send(1'b1, 32'hC049_0FDB, mk(1, 1, 8'h80, 24'hC9_0FDB, 0, 0, 0));
    send(1'b0, 32'hDEAD_3C00, mk(0, 0, 8'h0F, 24'h00_0400, 0, 0, 0));
    send(1'b0, 32'h0000_7E00, mk(0, 0, 8'h1F, 24'h00_0600, 0, 0, 1));
    idle();
    repeat (3) @(posedge clk); #1;

    // fill to DEPTH with consumer stalled; third word must wait
    bus.out_ready = 1'b0;
    send(1'b1, 32'h4000_0000, mk(1, 0, 8'h80, 24'h80_0000, 0, 0, 0));
    send(1'b0, 32'h0000_BC00, mk(0, 1, 8'h0F, 24'h00_0400, 0, 0, 0));
    fork
      send(1'b0, 32'h0000_7C00, mk(0, 0, 8'h1F, 24'h00_0400, 0, 1, 0));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("full_in_ready", 64'(bus.in_ready), 64'd0);
          check("stall_hold", 64'({bus.unp_e, bus.unp_m}), 64'({8'h80, 24'h80_0000}));
        end
        bus.out_ready = 1'b1;
      end
    join
    idle();
    repeat (4) @(posedge clk); #1;

    // asynchronous reset with two entries stored
    bus.out_ready = 1'b0;
    send(1'b1, 32'h3F80_0000, mk(1, 0, 8'h7F, 24'h80_0000, 0, 0, 0));
    send(1'b1, 32'h4000_0000, mk(1, 0, 8'h80, 24'h80_0000, 0, 0, 0));
    idle();
    check("pre_rst_full", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    check("arst_unp", 64'({bus.unp_op, bus.unp_s, bus.unp_e, bus.unp_m, bus.unp_zero, bus.unp_inf, bus.unp_nan}), 64'd0);
    n_disc += sb.size();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h0000_4000, mk(0, 0, 8'h10, 24'h00_0400, 0, 0, 0));
    idle();

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("out_count", 64'(n_out), 64'(n_sent - n_disc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
